pll_lock_supervisor: RTL

- Controller at the far end of a PLL's rst/locked interface.
- Runs on the PLL reference clock and drives the PLL reset with a fixed-length pulse.
- Synchronizes and qualifies the asynchronous locked flag, and holds downstream logic in reset until lock has been stable for a programmable time.
- Detects loss of lock, re-issues the PLL reset with bounded retries, and reports status and counters to the control CPU.

---
 rtl/pll_sup_pkg.sv | 24 ++
 rtl/bit_sync_2ff.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    // Saturation point of the lock-loss counter.
    localparam logic [7:0] UNLOCK_SAT = 8'd255;

    // Width needed for a counter that must hold the largest of three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module bit_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input; rst clears both stages.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make both stages sample on the same edge, so the chain really is two flops deep.
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, releases
// the downstream reset, and retries or gives up when lock does not arrive.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 32,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRIES      = 7,
    parameter int CNT_W            = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       pll_ok_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] unlock_cnt_o
);

    // Terminal values of the shared cycle counter in each timed state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that saw lock already counts as the first qualified
    // sample, so STABLE needs LOCK_STABLE_CYC-1 more of them (cnt 0..N-2).
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYC >= 2) ? LOCK_STABLE_CYC - 2 : 0);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       retry_nxt;
    logic [3:0]       retry_inc;
    logic [7:0]       unlock_nxt;
    logic             lk_s;

    bit_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked_i),
        .q   (lk_s)
    );

    assign cnt_inc   = cnt + CNT_W'(1);
    assign retry_inc = retry_cnt_o + 4'd1;

    // Next-state and counter update rules; relock beats lock, lock beats timeout.
    always_comb begin
        // NOTE: every target gets its hold value first so no path leaves it unassigned and infers a latch.
        state_nxt  = state;
        cnt_nxt    = cnt;
        retry_nxt  = retry_cnt_o;
        unlock_nxt = unlock_cnt_o;

        case (state)
            PLL_RST: begin
                // Relock is ignored here so a pulse is never stretched.
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            WAIT_LOCK: begin
                if (relock_req_i) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end else if (lk_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_inc;
                    cnt_nxt   = '0;
                    state_nxt = (retry_inc == RETRY_LIMIT) ? FAIL : PLL_RST;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            STABLE: begin
                if (relock_req_i) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end else if (!lk_s) begin
                    // Lock dropped while qualifying: restart the timeout window.
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    retry_nxt = 4'd0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            RUN: begin
                if (!lk_s && (unlock_cnt_o != UNLOCK_SAT)) begin
                    unlock_nxt = unlock_cnt_o + 8'd1;
                end
                if (relock_req_i || !lk_s) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end
            end

            FAIL: begin
                if (relock_req_i) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                    retry_nxt = 4'd0;
                end
            end

            default: begin
                state_nxt = PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counters and outputs; outputs decode the next state so they move with it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= PLL_RST;
            cnt          <= '0;
            retry_cnt_o  <= 4'd0;
            unlock_cnt_o <= 8'd0;
            pll_rst_o    <= 1'b1;
            sys_rst_o    <= 1'b1;
            pll_ok_o     <= 1'b0;
            fail_o       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            retry_cnt_o  <= retry_nxt;
            unlock_cnt_o <= unlock_nxt;
            pll_rst_o    <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
            sys_rst_o    <= (state_nxt != RUN);
            pll_ok_o     <= (state_nxt == RUN);
            fail_o       <= (state_nxt == FAIL);
        end
    end

endmodule
